circuito: RTL and testbench

CIRCUITO -- requirements
Module: circuito

---
 rtl/circuito_pkg.sv | 20 ++
 rtl/circuito_if.sv | 19 +
 rtl/circuito_lut.sv | 16 +
 rtl/circuito.sv | 68 ++++++
 tb/tb_circuito.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/circuito_pkg.sv
// circuito_pkg -- shared constants for the circuito 4-input function block.
//   TT_DEFAULT  : default truth table (odd parity of A,B,C,D)
//   IDX_W       : width of the function index {A,B,C,D}
//   TT_W        : number of truth-table entries (2**IDX_W)
//   SYNC_DEPTH  : flops per input in the optional synchronizer
package circuito_pkg;

    localparam int IDX_W      = 4;
    localparam int TT_W       = 1 << IDX_W;
    localparam int SYNC_DEPTH = 2;

    localparam logic [TT_W-1:0] TT_DEFAULT = 16'h6996;

    // Packs the four function inputs into the table index, A as MSB.
    function automatic logic [IDX_W-1:0] pack_idx(input logic a, input logic b,
                                                  input logic c, input logic d);
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/circuito_if.sv
// circuito_if -- groups the function inputs and the registered output.
//   A,B,C,D : function inputs (A = index MSB, D = index LSB)
//   S       : registered function output
// There is no handshake: every rising clock edge takes a new sample and
// S is valid on every cycle.
//   master : drives A..D, observes S (environment side)
//   slave  : observes A..D, drives S (circuito side)
interface circuito_if;

    logic A;
    logic B;
    logic C;
    logic D;
    logic S;

    modport master (output A, output B, output C, output D, input S);
    modport slave  (input A, input B, input C, input D, output S);

endinterface

// File: rtl/circuito_lut.sv
// circuito_lut -- purely combinational 16:1 selection of TRUTH_TABLE by idx.
//   idx : 4-bit table index {A,B,C,D}
//   s   : TRUTH_TABLE[idx]
// Every index value is a legal entry; there are no don't-care codes.
module circuito_lut
    import circuito_pkg::*;
#(
    parameter logic [TT_W-1:0] TRUTH_TABLE = TT_DEFAULT
) (
    input  logic [IDX_W-1:0] idx,
    output logic             s
);

    assign s = TRUTH_TABLE[idx];

endmodule

// File: rtl/circuito.sv
// circuito -- registered 4-input boolean function defined by a truth table.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset, clears every flop
//   bus   : circuito_if.slave carrying A,B,C,D in and S out
// Parameter TRUTH_TABLE: bit i is S for index i = {A,B,C,D}.
// Build option CIRCUITO_SYNC_EN: when defined, each input passes through a
// two-flop synchronizer before index formation (latency 3 edges); when
// undefined the inputs feed the table directly (latency 1 edge).
// S always comes straight from a flop, so no input glitch reaches it and
// a multi-input change appears on S as a single new value.
module circuito
    import circuito_pkg::*;
#(
    parameter logic [TT_W-1:0] TRUTH_TABLE = TT_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    circuito_if.slave bus
);

    logic [IDX_W-1:0] idx_raw;
    logic [IDX_W-1:0] idx;
    logic             s_next;
    logic             s_q;

    assign idx_raw = pack_idx(bus.A, bus.B, bus.C, bus.D);

`ifdef CIRCUITO_SYNC_EN
    // Stage 0 may go metastable on asynchronous inputs; only the last stage
    // is allowed to reach the table.
    logic [IDX_W-1:0] sync_q [SYNC_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= idx_raw;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign idx = sync_q[SYNC_DEPTH-1];
`else
    assign idx = idx_raw;
`endif

    circuito_lut #(
        .TRUTH_TABLE (TRUTH_TABLE)
    ) u_lut (
        .idx (idx),
        .s   (s_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s_next;
        end
    end

    assign bus.S = s_q;

endmodule

// File: tb/tb_circuito.sv
// tb_circuito -- self-checking bench for circuito.
// Two instances run in lockstep: one with the default table (odd parity)
// and one with TRUTH_TABLE = 16'h8000 (S = 1 only for index 1111).
// The driver changes inputs/reset on the falling edge and pushes the
// expected pair into exp_q; the monitor pops one entry per rising edge,
// ages it through the output latency and compares S just after the edge.
module tb_circuito;

`ifdef CIRCUITO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    circuito_if bus0 ();
    circuito_if bus1 ();

    circuito #(.TRUTH_TABLE(16'h6996)) dut_par (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    circuito #(.TRUTH_TABLE(16'h8000)) dut_and (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // bit 1: all-ones detector, bit 0: odd parity
    logic [1:0] exp_q[$];
    logic [1:0] pend[$];

    function automatic logic [1:0] ref_model(input logic [3:0] idx);
        logic par;
        logic all1;
        par  = ($countones(idx) % 2) == 1;
        all1 = (idx == 4'd15);
        return {all1, par};
    endfunction

    task automatic check(input string name, input logic [1:0] act,
                         input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: S pair got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus: inputs and reset change on the falling edge.
    task automatic drive(input logic [3:0] idx, input logic rst);
        @(negedge clk);
        rst_n = rst;
        {bus0.A, bus0.B, bus0.C, bus0.D} = idx;
        {bus1.A, bus1.B, bus1.C, bus1.D} = idx;
        exp_q.push_back(ref_model(idx));
        if (!rst) begin
            #1 check("async_reset", {bus1.S, bus0.S}, 2'b00);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [1:0] v;
        logic [1:0] e;
        forever begin
            @(posedge clk);
            if (exp_q.size() == 0) continue;
            v = exp_q.pop_front();
            if (!rst_n) begin
                pend.delete();
                for (int i = 0; i < LAT - 1; i++) pend.push_back(2'b00);
                #1 check("in_reset", {bus1.S, bus0.S}, 2'b00);
            end else begin
                pend.push_back(v);
                e = pend.pop_front();
                #1 check("s_out", {bus1.S, bus0.S}, e);
            end
        end
    end

    initial begin
        logic [3:0] hold;
        rst_n = 1'b0;
        {bus0.A, bus0.B, bus0.C, bus0.D} = 4'd0;
        {bus1.A, bus1.B, bus1.C, bus1.D} = 4'd0;

        // Reset held while inputs toggle around 1111
        for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 4'hF : 4'h0, 1'b0);
        drive(4'hF, 1'b1);
        drive(4'h0, 1'b1);
        drive(4'h0, 1'b1);
        drive(4'h0, 1'b1);

        // Single 0001 after idle zeros (latency probe)
        drive(4'h1, 1'b1);
        for (int i = 0; i < 4; i++) drive(4'h0, 1'b1);

        // Full sweep 0..15
        for (int i = 0; i < 16; i++) drive(4'(i), 1'b1);

        // Wrap 1111 -> 0000 -> 0001
        drive(4'hF, 1'b1);
        drive(4'h0, 1'b1);
        drive(4'h1, 1'b1);

        // Random, multi-input changes
        for (int i = 0; i < 200; i++) drive(4'($urandom_range(0, 15)), 1'b1);

        // Constant pattern holds S steady
        hold = 4'($urandom_range(0, 15));
        for (int i = 0; i < 12; i++) drive(hold, 1'b1);
        for (int i = 0; i < 12; i++) drive(4'hF, 1'b1);

        // Reset in the middle of a busy pipeline
        for (int k = 0; k < 4; k++) begin
            drive(4'hF, 1'b1);
            drive(4'h7, 1'b1);
            drive(4'h1, 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                drive(4'($urandom_range(0, 15)), 1'b0);
            for (int i = 0; i < 6; i++) drive(4'($urandom_range(0, 15)), 1'b1);
            drive(4'h0, 1'b1);
            drive(4'h0, 1'b1);
        end

        // More random traffic, then flush
        for (int i = 0; i < 150; i++) drive(4'($urandom_range(0, 15)), 1'b1);
        for (int i = 0; i < LAT + 2; i++) drive(4'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
